// File: rtl/banco_registradores_hex_if.sv
// Bus bundle for the register-file/decode/display cluster.
// fsm_state mirrors the display FSM state (BLANK=0, VIEW_A=1, VIEW_B=2, WB=3).
interface banco_registradores_hex_if;
  logic [3:0]  codop;
  logic [3:0]  entrada1;
  logic [3:0]  entrada2;
  logic [3:0]  entrada3;
  logic        sinal;
  logic [15:0] dado;
  logic [15:0] saida1;
  logic [15:0] saida2;
  logic [15:0] saida3;
  logic        esccondcp;
  logic        esccp;
  logic [1:0]  fontecp;
  logic        escreg;
  logic [7:0]  mode;
  logic [31:0] display;
  logic [1:0]  fsm_state;

  // sinal is a plain write strobe: one write per edge it is high, no ready/backpressure.
  modport master (
    output codop, entrada1, entrada2, entrada3, sinal, dado,
    input  saida1, saida2, saida3, esccondcp, esccp, fontecp, escreg,
    input  mode, display, fsm_state
  );

  modport slave (
    input  codop, entrada1, entrada2, entrada3, sinal, dado,
    output saida1, saida2, saida3, esccondcp, esccp, fontecp, escreg,
    output mode, display, fsm_state
  );
endinterface

// File: rtl/banco_registradores_hex.sv
// 16x16 register file, opcode decoder and 7-segment display FSM of the 3-stage CPU.
// Optional write-through on the read ports: define REGFILE_BYPASS_EN.
module banco_registradores_hex (
  input logic                     clk,
  input logic                     reset,
  banco_registradores_hex_if.slave bus
);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    VIEW_A = 2'd1,
    VIEW_B = 2'd2,
    WB     = 2'd3
  } disp_state_t;

  logic [15:0] regs [16];
  logic [15:0] rd1, rd2, rd3;

  disp_state_t state_q, state_d;
  logic [1:0]  hold_q, hold_d;
  logic [15:0] cap_q, cap_d;
  logic [31:0] display_q, display_d;
  logic [7:0]  mode_q, mode_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (bus.sinal) begin
      regs[bus.entrada3] <= bus.dado;
    end
  end

  always_comb begin
    rd1 = regs[bus.entrada1];
    rd2 = regs[bus.entrada2];
    rd3 = regs[bus.entrada3];
`ifdef REGFILE_BYPASS_EN
    if (bus.sinal && bus.entrada1 == bus.entrada3) rd1 = bus.dado;
    if (bus.sinal && bus.entrada2 == bus.entrada3) rd2 = bus.dado;
    if (bus.sinal) rd3 = bus.dado;
`endif
  end

  assign bus.saida1 = rd1;
  assign bus.saida2 = rd2;
  assign bus.saida3 = rd3;

  always_comb begin
    bus.escreg    = 1'b0;
    bus.esccp     = 1'b0;
    bus.esccondcp = 1'b0;
    bus.fontecp   = 2'b00;
    case (bus.codop)
      4'b1011: begin
        bus.esccp   = 1'b1;
        bus.fontecp = 2'b10;
      end
      4'b1100: begin
        bus.esccondcp = 1'b1;
        bus.fontecp   = 2'b01;
      end
      4'b1111: ;
      default: bus.escreg = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= BLANK;
      hold_q    <= '0;
      cap_q     <= '0;
      display_q <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cap_q     <= cap_d;
      display_q <= display_d;
      mode_q    <= mode_d;
    end
  end

  // A write always wins; WB leaves only once the hold count has already run down to 0.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cap_d   = cap_q;
    if (bus.sinal) begin
      state_d = WB;
      hold_d  = 2'd2;
      cap_d   = bus.dado;
    end else begin
      case (state_q)
        BLANK:  state_d = VIEW_A;
        VIEW_A: state_d = VIEW_B;
        VIEW_B: state_d = VIEW_A;
        WB: begin
          if (hold_q == 2'd0) state_d = VIEW_A;
          else                hold_d  = hold_q - 2'd1;
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // Display registers load from the next state so the view tracks this cycle's reads.
  always_comb begin
    display_d = '0;
    mode_d    = 8'h00;
    case (state_d)
      VIEW_A: begin
        display_d = {rd1, rd2};
        mode_d    = 8'hFF;
      end
      VIEW_B: begin
        display_d = {16'h0000, rd3};
        mode_d    = 8'h0F;
      end
      WB: begin
        display_d = {16'h0000, cap_d};
        mode_d    = 8'h0F;
      end
      default: ;
    endcase
  end

  assign bus.display   = display_q;
  assign bus.mode      = mode_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_banco_registradores_hex.sv
// Directed bench for banco_registradores_hex: decoder table plus register/display sequences.
module tb_banco_registradores_hex;

  localparam logic [1:0] S_BLANK  = 2'd0;
  localparam logic [1:0] S_VIEW_A = 2'd1;
  localparam logic [1:0] S_VIEW_B = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  banco_registradores_hex_if bus ();

  banco_registradores_hex dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] codop;
    logic [4:0] ctrl;   // {escreg, esccp, esccondcp, fontecp}
  } dec_vec_t;

  dec_vec_t dec_tab [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    bus.entrada3 = addr;
    bus.dado     = data;
    bus.sinal    = 1'b1;
    tick();
    bus.sinal    = 1'b0;
  endtask

  task automatic check_view(input string name, input logic [31:0] disp,
                            input logic [7:0] md, input logic [1:0] st);
    check({name, "_display"}, bus.display, disp);
    check({name, "_mode"}, {24'h0, bus.mode}, {24'h0, md});
    check({name, "_state"}, {30'h0, bus.fsm_state}, {30'h0, st});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) begin
      dec_tab[i].codop = 4'(i);
      dec_tab[i].ctrl  = 5'b1_0_0_00;
    end
    dec_tab[11].ctrl = 5'b0_1_0_10;
    dec_tab[12].ctrl = 5'b0_0_1_01;
    dec_tab[15].ctrl = 5'b0_0_0_00;

    reset        = 1'b0;
    bus.codop    = '0;
    bus.entrada1 = '0;
    bus.entrada2 = '0;
    bus.entrada3 = '0;
    bus.sinal    = 1'b0;
    bus.dado     = '0;
    #3;
    check_view("reset", 32'h0, 8'h00, S_BLANK);
    check("reset_saida1", {16'h0, bus.saida1}, 32'h0);

    tick();
    reset = 1'b1;
    tick();
    check_view("release", 32'h0000_0000, 8'hFF, S_VIEW_A);

    // Preload R5 then pulse reset between edges.
    wr(4'd5, 16'h1234);
    bus.entrada1 = 4'd5;
    #1;
    check("preload_r5", {16'h0, bus.saida1}, 32'h1234);
    #1 reset = 1'b0;
    #1;
    check("async_reset_r5", {16'h0, bus.saida1}, 32'h0);
    check_view("async_reset", 32'h0, 8'h00, S_BLANK);
    reset = 1'b1;
    tick();

    // Same-cycle read of the register being written.
    bus.entrada3 = 4'd3;
    bus.dado     = 16'hBEEF;
    bus.sinal    = 1'b1;
    bus.entrada1 = 4'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_saida1", {16'h0, bus.saida1}, 32'hBEEF);
    check("same_cycle_saida3", {16'h0, bus.saida3}, 32'hBEEF);
`else
    check("same_cycle_saida1", {16'h0, bus.saida1}, 32'h0);
    check("same_cycle_saida3", {16'h0, bus.saida3}, 32'h0);
`endif
    tick();
    bus.sinal = 1'b0;
    #1;
    check("after_write_r3", {16'h0, bus.saida1}, 32'hBEEF);

    // No write when sinal is low.
    bus.entrada3 = 4'd9;
    bus.dado     = 16'hFFFF;
    tick();
    bus.entrada1 = 4'd9;
    #1;
    check("no_write_r9", {16'h0, bus.saida1}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      bus.codop = dec_tab[i].codop;
      #1;
      check($sformatf("decode_%0d", i),
            {27'h0, bus.escreg, bus.esccp, bus.esccondcp, bus.fontecp},
            {27'h0, dec_tab[i].ctrl});
    end

    // Rotation between VIEW_A and VIEW_B after the write-back view drains.
    tick();
    wr(4'd1, 16'h00AA);
    wr(4'd2, 16'h00BB);
    wr(4'd4, 16'h0CCC);
    check_view("wb_r4", 32'h0000_0CCC, 8'h0F, S_WB);
    bus.entrada1 = 4'd1;
    bus.entrada2 = 4'd2;
    bus.entrada3 = 4'd4;
    tick();
    check_view("wb_r4_hold1", 32'h0000_0CCC, 8'h0F, S_WB);
    tick();
    check_view("wb_r4_hold0", 32'h0000_0CCC, 8'h0F, S_WB);
    tick();
    check_view("rot_a0", 32'h00AA_00BB, 8'hFF, S_VIEW_A);
    tick();
    check_view("rot_b0", 32'h0000_0CCC, 8'h0F, S_VIEW_B);
    tick();
    check_view("rot_a1", 32'h00AA_00BB, 8'hFF, S_VIEW_A);

    // Single write-back: capture plus two hold edges, then VIEW_A.
    wr(4'd6, 16'h5A5A);
    bus.entrada3 = 4'd4;
    for (int k = 0; k < 3; k++) begin
      check_view($sformatf("wb_5a5a_%0d", k), 32'h0000_5A5A, 8'h0F, S_WB);
      tick();
    end
    check_view("wb_exit", 32'h00AA_00BB, 8'hFF, S_VIEW_A);

    // Back-to-back writes restart capture and hold.
    bus.entrada3 = 4'd7;
    bus.dado     = 16'h1111;
    bus.sinal    = 1'b1;
    tick();
    check_view("b2b_first", 32'h0000_1111, 8'h0F, S_WB);
    bus.dado = 16'h2222;
    tick();
    bus.sinal = 1'b0;
    check_view("b2b_second", 32'h0000_2222, 8'h0F, S_WB);
    tick();
    check_view("b2b_hold1", 32'h0000_2222, 8'h0F, S_WB);
    tick();
    check_view("b2b_hold0", 32'h0000_2222, 8'h0F, S_WB);
    tick();
    check_view("b2b_exit", 32'h00AA_00BB, 8'hFF, S_VIEW_A);
    bus.entrada1 = 4'd7;
    #1;
    check("b2b_r7", {16'h0, bus.saida1}, 32'h2222);

    // Reset in the middle of a write-back view.
    wr(4'd8, 16'h7777);
    check_view("mid_wb", 32'h0000_7777, 8'h0F, S_WB);
    #1 reset = 1'b0;
    #1;
    check_view("mid_wb_reset", 32'h0, 8'h00, S_BLANK);
    check("mid_wb_reset_r7", {16'h0, bus.saida1}, 32'h0);
    reset = 1'b1;
    tick();
    check_view("mid_wb_release", 32'h0000_0000, 8'hFF, S_VIEW_A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
